// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Scoreboard entry layout and opcode-class decode helpers.
package hazard_pkg;

    // Select value meaning "take the operand from the register file"
    localparam int SEL_RF = 0;

    // Scoreboard entry layout, LSB first: load, addr[aw], wr, valid
    localparam int ENT_LOAD = 0;
    localparam int ENT_ADDR = 1;

    function automatic int ent_w(input int aw);
        return aw + 3;
    endfunction

    function automatic int ent_wr(input int aw);
        return aw + 1;
    endfunction

    function automatic int ent_valid(input int aw);
        return aw + 2;
    endfunction

    // Opcode classes shared with the decoder
    typedef enum logic [1:0] {
        OPC_ALU    = 2'd0,
        OPC_LOAD   = 2'd1,
        OPC_STORE  = 2'd2,
        OPC_BRANCH = 2'd3
    } op_class_e;

    function automatic logic opc_wr_en(input op_class_e c);
        return (c == OPC_ALU) || (c == OPC_LOAD);
    endfunction

    function automatic logic opc_is_load(input op_class_e c);
        return c == OPC_LOAD;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_match.sv
// Priority matcher: finds the youngest in-flight producer of one
// source register and flags a load whose data is not ready yet.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int FW_DEPTH = 2,
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int SEL_W    = 2
) (
    input  logic [REG_AW-1:0]                   src,
    input  logic                                used,
    input  logic [FW_DEPTH*ent_w(REG_AW)-1:0]   ents,
    output logic                                hit,
    output logic [SEL_W-1:0]                    idx,
    output logic                                load_hazard
);

    localparam int EW = ent_w(REG_AW);
    localparam int VB = ent_valid(REG_AW);
    localparam int WB = ent_wr(REG_AW);

    logic          blocked;
    logic [EW-1:0] e;

    assign blocked = (ZERO_REG != 0) && (src == '0);

    // Scan oldest to youngest so the lowest matching index wins
    always_comb begin
        hit         = 1'b0;
        idx         = '0;
        load_hazard = 1'b0;
        e           = '0;
        for (int k = FW_DEPTH - 1; k >= 0; k--) begin
            e = ents[k*EW +: EW];
            if (used && !blocked && e[VB] && e[WB] &&
                e[ENT_ADDR +: REG_AW] == src) begin
                hit         = 1'b1;
                idx         = SEL_W'(k);
                load_hazard = e[ENT_LOAD] && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller at the ID/EX boundary: tracks
// in-flight destinations, registers forward selects, muxes EX operands.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int FW_DEPTH = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int SEL_W    = $clog2(FW_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_AW-1:0]          id_rs_addr,
    input  logic                       id_rs_used,
    input  logic [REG_AW-1:0]          id_rt_addr,
    input  logic                       id_rt_used,
    input  logic [REG_AW-1:0]          id_rd_addr,
    input  logic                       id_wr_en,
    input  logic                       id_is_load,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          rf_op1,
    input  logic [DATA_W-1:0]          rf_op2,
    input  logic [FW_DEPTH*DATA_W-1:0] fw_data,
    output logic                       stall,
    output logic [SEL_W-1:0]           op1_sel,
    output logic [SEL_W-1:0]           op2_sel,
    output logic [DATA_W-1:0]          fw_op1,
    output logic [DATA_W-1:0]          fw_op2,
    output logic [15:0]                stall_cnt
);

    localparam int EW = ent_w(REG_AW);
    localparam int VB = ent_valid(REG_AW);
    localparam int WB = ent_wr(REG_AW);

    logic [FW_DEPTH*EW-1:0] sb;
    logic [EW-1:0]          new_ent;
    logic                   hit1, hit2, haz1, haz2, issue;
    logic [SEL_W-1:0]       idx1, idx2;

    fwd_match #(
        .FW_DEPTH(FW_DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT),
        .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
    ) u_match1 (
        .src(id_rs_addr), .used(id_rs_used), .ents(sb),
        .hit(hit1), .idx(idx1), .load_hazard(haz1)
    );

    fwd_match #(
        .FW_DEPTH(FW_DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT),
        .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
    ) u_match2 (
        .src(id_rt_addr), .used(id_rt_used), .ents(sb),
        .hit(hit2), .idx(idx2), .load_hazard(haz2)
    );

    assign stall = id_valid && !flush && (haz1 || haz2);
    assign issue = id_valid && !flush && !stall;

    // Entry for the ID instruction; a stall turns it into a bubble
    always_comb begin
        new_ent                      = '0;
        new_ent[VB]                  = id_valid && !stall;
        new_ent[WB]                  = id_wr_en &&
                                       !(ZERO_REG != 0 && id_rd_addr == '0);
        new_ent[ENT_ADDR +: REG_AW]  = id_rd_addr;
        new_ent[ENT_LOAD]            = id_is_load;
    end

    // Scoreboard shift; the oldest entry drops off the end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sb <= '0;
        end else begin
            for (int k = FW_DEPTH - 1; k > 0; k--)
                sb[k*EW +: EW] <= sb[(k-1)*EW +: EW];
            sb[0 +: EW] <= new_ent;
        end
    end

    // Register EX operand selects for the issuing instruction
    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            op1_sel <= SEL_W'(SEL_RF);
            op2_sel <= SEL_W'(SEL_RF);
        end else begin
            op1_sel <= hit1 ? idx1 + SEL_W'(1) : SEL_W'(SEL_RF);
            op2_sel <= hit2 ? idx2 + SEL_W'(1) : SEL_W'(SEL_RF);
        end
    end

    // Saturating count of stall cycles, survives flush
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    // EX forwarding mux driven by the registered selects
    always_comb begin
        fw_op1 = rf_op1;
        fw_op2 = rf_op2;
        for (int k = 0; k < FW_DEPTH; k++) begin
            if (op1_sel == SEL_W'(k + 1))
                fw_op1 = fw_data[k*DATA_W +: DATA_W];
            if (op2_sel == SEL_W'(k + 1))
                fw_op2 = fw_data[k*DATA_W +: DATA_W];
        end
    end

endmodule
